// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: load-use interlock,
// mispredict flush, and memory-wait stall with a sticky timeout fault.
module pipeline_ctrl #(
  parameter int unsigned MAX_WAIT = 4  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_uses_rs2,
  input  logic        ID_EX_memread,
  input  logic [4:0]  ID_EX_rd,
  input  logic        EX_branch,
  input  logic        EX_mispredict,
  input  logic        MEM_req,
  input  logic        MEM_ack,
  output logic        pc_stall,
  output logic        IF_ID_stall,
  output logic        ID_EX_stall,
  output logic        EX_MEM_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        MEM_WB_bubble,
  output logic        mem_timeout,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_e;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic lu, mh, mp;

  assign lu = ID_EX_memread && (ID_EX_rd != 5'd0) &&
              ((ID_EX_rd == ID_rs1) || (ID_uses_rs2 && (ID_EX_rd == ID_rs2)));
  assign mh = MEM_req && !MEM_ack;
  assign mp = EX_branch && EX_mispredict;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pc_stall      = 1'b0;
    IF_ID_stall   = 1'b0;
    ID_EX_stall   = 1'b0;
    EX_MEM_stall  = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    MEM_WB_bubble = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mh) begin
          {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_bubble} = '1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (mp) begin
          // The ID instruction is squashed, so a coincident load-use is moot.
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
        end else if (lu) begin
          pc_stall    = 1'b1;
          IF_ID_stall = 1'b1;
          ID_EX_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MEM_ack) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_bubble} = '1;
          if (wait_cnt_q == WAIT_LIMIT) state_d = FAULT;
          else                          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      FAULT: begin
        {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_bubble} = '1;
      end
      default: state_d = RUN;
    endcase

    // Outputs must read zero the moment reset asserts, not one edge later.
    if (!rst_n) begin
      {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall} = '0;
      {IF_ID_flush, ID_EX_flush, MEM_WB_bubble}           = '0;
    end

    stall_count_d = stall_count_q;
    if (pc_stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_timeout = (state_q == FAULT);
  assign ctrl_state  = state_q;
  assign stall_count = stall_count_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 4, is the number of MEM_WAIT cycles allowed before timeout; legal range is 1..255.
REQ-002 clk  in  1  the single clock; all state updates occur on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 ID_rs1  in  5  rs1 index of the instruction in ID.
REQ-005 ID_rs2  in  5  rs2 index of the instruction in ID.
REQ-006 ID_uses_rs2  in  1  the ID instruction reads rs2 (R-type, store, conditional branch).
REQ-007 ID_EX_memread  in  1  the instruction in EX is a load.
REQ-008 ID_EX_rd  in  5  destination index of the instruction in EX.
REQ-009 EX_branch  in  1  a branch or jump is resolving in EX this cycle.
REQ-010 EX_mispredict  in  1  EX branch outcome differs from the fetched take bit; qualified by EX_branch.
REQ-011 MEM_req  in  1  the instruction in MEM accesses data memory.
REQ-012 MEM_ack  in  1  data memory completes the access this cycle.
REQ-013 Stall outputs, each out 1, hold their register:
- pc_stall: hold PC.
- IF_ID_stall, ID_EX_stall, EX_MEM_stall: hold the corresponding pipeline register.
REQ-014 Flush and bubble outputs, each out 1:
- IF_ID_flush, ID_EX_flush: load a NOP into the register.
- MEM_WB_bubble: write a NOP to MEM_WB (regwrite=0).
REQ-015 mem_timeout  out  1  sticky memory-timeout fault flag.
REQ-016 ctrl_state  out  2  current FSM state: RUN=00, MEM_WAIT=01, FAULT=10.
REQ-017 stall_count  out  16  saturating count of cycles in which pc_stall was 1.

Function
REQ-018 FSM state, wait_cnt (8 bit), and stall_count are registered; all stall, flush and bubble outputs are combinational from state and current inputs.
REQ-019 Load-use hazard (LU) SHALL be ID_EX_memread & (ID_EX_rd!=0) & ((ID_EX_rd==ID_rs1) | (ID_uses_rs2 & ID_EX_rd==ID_rs2)).
REQ-020 Memory hazard (MH) SHALL be MEM_req & ~MEM_ack; mispredict (MP) SHALL be EX_branch & EX_mispredict.
REQ-021 In RUN, priority SHALL be MH > MP > LU; at most one action applies per cycle.
REQ-022 RUN with MH:
- pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall and MEM_WB_bubble = 1; flushes = 0.
- next state MEM_WAIT; wait_cnt <= 1.
REQ-023 RUN with MP and no MH:
- IF_ID_flush = ID_EX_flush = 1; no stall.
- LU is suppressed, because the ID instruction is squashed.
- state stays RUN.
REQ-024 RUN with LU only: pc_stall = IF_ID_stall = ID_EX_flush = 1; all else 0; state stays RUN; the stall lasts exactly one cycle per hazard occurrence.
REQ-025 RUN with no hazard: all stall, flush and bubble outputs = 0.
REQ-026 MEM_WAIT with MEM_ack=1:
- all stall, flush and bubble outputs = 0; the pipeline advances this cycle.
- next state RUN; wait_cnt <= 0.
REQ-027 MEM_WAIT with MEM_ack=0: outputs as in REQ-022.
- if wait_cnt==MAX_WAIT: next state FAULT.
- otherwise wait_cnt <= wait_cnt+1.
REQ-028 In MEM_WAIT, MP and LU SHALL be ignored; the frozen EX stage re-presents them after release.
REQ-029 In FAULT:
- all four stalls and MEM_WB_bubble = 1; flushes = 0; mem_timeout = 1.
- MEM_ack is ignored; FAULT exits only on reset.
REQ-030 Consequently, FAULT SHALL be entered after MAX_WAIT+1 consecutive stalled cycles without ack.
REQ-031 stall_count SHALL increment on each clock edge where pc_stall==1; it saturates at 0xFFFF and does not wrap.
REQ-032 A same-cycle MEM_req & MEM_ack in RUN SHALL cause no stall.

Reset
REQ-033 On rst_n=0, immediately and without waiting for clk:
- state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0, ctrl_state=00.
- all stall, flush and bubble outputs = 0 while rst_n=0, regardless of inputs.
REQ-034 Reset asserted in MEM_WAIT or FAULT SHALL abandon the pending access; the first edge after deassertion evaluates from RUN.

Verification
REQ-035 Load-use: ID_EX_memread=1, ID_EX_rd=5, ID_rs1=5 for 1 cycle -> pc_stall=IF_ID_stall=ID_EX_flush=1 that cycle only; stall_count 0->1.
REQ-036 rd=x0: ID_EX_memread=1, ID_EX_rd=0, ID_rs1=0 -> no stall; ID_rs2 match with ID_uses_rs2=0 -> no stall.
REQ-037 Mispredict plus load-use in the same RUN cycle -> IF_ID_flush=ID_EX_flush=1, pc_stall=0.
REQ-038 MAX_WAIT=4, MEM_req=1, ack after 3 cycles:
- stalls asserted for 3 cycles, released on the ack cycle.
- ctrl_state sequence 00,01,01,01 -> 00; stall_count=3.
REQ-039 Timeout, MAX_WAIT=4, MEM_req=1 with no ack:
- ctrl_state reaches 10 after 5 stalled cycles; mem_timeout=1.
- a later MEM_ack=1 leaves state at 10.
REQ-040 rst_n pulsed low mid-MEM_WAIT, between edges -> outputs zero immediately and ctrl_state=00; saturation check: force 65540 stalled cycles -> stall_count=0xFFFF.
